instruction_memory: RTL

// Backing instruction store directly downstream of the instruction cache in the RV32IM fetch path.

---
 rtl/instruction_memory.sv | 89 ++++++++
 1 files changed

// File: rtl/instruction_memory.sv
// Backing instruction store behind the I-cache: 128-bit block refills with a fixed
// access latency, plus a word-wide program-load port usable while the reader is idle.
module instruction_memory #(
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mem_read,
  input  logic [27:0]  mem_address,
  output logic [127:0] mem_readinst,
  output logic         mem_busywait,
  input  logic         ld_en,
  input  logic [29:0]  ld_addr,
  input  logic [31:0]  ld_data,
  output logic         ld_ack
);

  localparam int          AW  = $clog2(MEM_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [27:0]  req_addr;
  logic [29:0]  req_word;
  logic         req_in_range;
  logic         ld_in_range;
  logic         ld_write;
  logic [127:0] block;
  logic [31:0]  mem [MEM_WORDS];

  assign req_word     = {req_addr, 2'b00};
  assign req_in_range = req_word < 30'(MEM_WORDS);
  assign ld_in_range  = ld_addr < 30'(MEM_WORDS);
  assign ld_write     = (state == IDLE) && ld_en;

  // Held high from the very first request cycle so the cache never sees a stale low.
  assign mem_busywait = mem_read && (state != READY);

  always_comb begin
    block = '0;
    for (int i = 0; i < 4; i++) begin
      block[32*i +: 32] = req_in_range ? mem[{req_word[AW-1:2], 2'(i)}] : NOP;
    end
  end

  // Storage is deliberately not reset so a loaded image survives a reset pulse.
  always_ff @(posedge clock) begin
    if (ld_write && ld_in_range) begin
      mem[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_addr     <= '0;
      mem_readinst <= '0;
      ld_ack       <= 1'b0;
    end else begin
      ld_ack <= ld_write;
      case (state)
        IDLE: begin
          if (mem_read && !ld_en) begin
            req_addr <= mem_address;
            cnt      <= 4'(READ_LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!mem_read) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mem_readinst <= block;
            state        <= READY;
          end
        end
        READY:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
